// File: rtl/pr_slot_ctrl_pkg.sv
// Shared definitions for the PR-slot freeze controller: FSM state encoding
// (also the CSR readback value on state_o) and default cycle counts.
package pr_slot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_FROZEN   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_UNFREEZE = 3'd5,
    ST_SWRST    = 3'd6
  } t_frz_state;

  localparam int unsigned DEF_NUM_BUSY        = 4;
  localparam int unsigned DEF_QUIET_CYCLES    = 16;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 32;
  localparam int unsigned DEF_SYNC_CYCLES     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 4096;
  localparam int unsigned DEF_CNT_W           = 13;

  // Larger of two cycle counts; used to size the shared counter ceiling.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pr_slot_quiet_detect.sv
// Consecutive-idle detector over a vector of activity flags. The count
// restarts on any busy bit and on clear_i; done_o fires in the cycle where
// QUIET_CYCLES consecutive idle cycles (this one included) have been seen.
module pr_slot_quiet_detect #(
  parameter int unsigned NUM_BUSY     = 4,
  parameter int unsigned QUIET_CYCLES = 16,
  parameter int unsigned CNT_W        = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic [NUM_BUSY-1:0] busy_i,
  output logic                done_o
);

  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             idle;

  assign idle   = (busy_i == '0);
  assign done_o = idle && (count_q == QUIET_LAST);

  // Next idle count: restart on activity or clear, saturate at the target.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count_d = count_q;
    if (clear_i || !idle) begin
      count_d = '0;
    end else if (count_q != QUIET_LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  // Idle count register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pr_slot_freeze_ctrl.sv
// PR-slot isolation sequencer: freezes the slot on a host PR request, waits
// for the slot interfaces to drain, holds the AFU in reset while PR runs,
// then releases freeze ahead of reset so downstream resynchronizers see an
// ordered sequence. All outputs are registered.
// Optional build macro PR_SLOT_DRAIN_TIMEOUT_EN: bounds the drain wait and
// raises the sticky drain_timeout flag when the bound expires.
module pr_slot_freeze_ctrl
  import pr_slot_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BUSY        = DEF_NUM_BUSY,
  parameter int unsigned QUIET_CYCLES    = DEF_QUIET_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned SYNC_CYCLES     = DEF_SYNC_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pr_req,
  input  logic                sw_reset_req,
  input  logic [NUM_BUSY-1:0] busy,
  output logic                pr_freeze,
  output logic                softreset,
  output logic                pr_ready,
  output logic [2:0]          state_o,
  output logic                drain_timeout
);

  localparam int unsigned CNT_MAX =
    max2(max2(QUIET_CYCLES, RST_HOLD_CYCLES), max2(SYNC_CYCLES, TIMEOUT_CYCLES));
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYCLES - 1);

  t_frz_state       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pr_freeze_q, pr_freeze_d;
  logic             softreset_q, softreset_d;
  logic             pr_ready_q, pr_ready_d;
  logic             quiet_done;

  // The idle count only runs while the FSM sits in DRAIN, so it starts at
  // zero on every DRAIN entry.
  pr_slot_quiet_detect #(
    .NUM_BUSY     (NUM_BUSY),
    .QUIET_CYCLES (QUIET_CYCLES),
    .CNT_W        (CNT_W)
  ) u_quiet (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != ST_DRAIN),
    .busy_i  (busy),
    .done_o  (quiet_done)
  );

`ifdef PR_SLOT_DRAIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic drain_timeout_q;
  logic timeout_hit;
`endif

  // Next-state logic; pr_req has priority over sw_reset_req in RUN, and an
  // abort (pr_req dropped) has priority over quiescence in DRAIN.
  always_comb begin
    state_d = state_q;
`ifdef PR_SLOT_DRAIN_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      ST_INIT:     if (cnt_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN: begin
        if (pr_req)            state_d = ST_DRAIN;
        else if (sw_reset_req) state_d = ST_SWRST;
      end
      ST_DRAIN: begin
        if (!pr_req)           state_d = ST_UNFREEZE;
        else if (quiet_done)   state_d = ST_FROZEN;
`ifdef PR_SLOT_DRAIN_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_FROZEN;
          timeout_hit = 1'b1;
        end
`endif
      end
      ST_FROZEN:   if (!pr_req) state_d = ST_HOLD;
      ST_HOLD:     if (cnt_q == HOLD_LAST) state_d = ST_UNFREEZE;
      ST_UNFREEZE: if (cnt_q == SYNC_LAST) state_d = ST_RUN;
      ST_SWRST:    if (cnt_q == HOLD_LAST) state_d = ST_RUN;
      default:     state_d = ST_INIT;
    endcase
  end

  // Shared dwell counter: zero on every state change, saturates otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output values for the state being entered, so the registered outputs
  // change on the same edge as state_q.
  always_comb begin
    pr_freeze_d = 1'b0;
    softreset_d = 1'b0;
    pr_ready_d  = 1'b0;
    unique case (state_d)
      ST_INIT:     softreset_d = 1'b1;
      ST_RUN:      ;
      ST_DRAIN:    pr_freeze_d = 1'b1;
      ST_FROZEN: begin
        pr_freeze_d = 1'b1;
        softreset_d = 1'b1;
        pr_ready_d  = 1'b1;
      end
      ST_HOLD: begin
        pr_freeze_d = 1'b1;
        softreset_d = 1'b1;
      end
      // Keeps reset as it was: asserted after HOLD, clear after an abort.
      ST_UNFREEZE: softreset_d = softreset_q;
      ST_SWRST:    softreset_d = 1'b1;
      default:     softreset_d = 1'b1;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      pr_freeze_q <= 1'b0;
      softreset_q <= 1'b1;
      pr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_freeze_q <= pr_freeze_d;
      softreset_q <= softreset_d;
      pr_ready_q  <= pr_ready_d;
    end
  end

`ifdef PR_SLOT_DRAIN_TIMEOUT_EN
  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      drain_timeout_q <= 1'b1;
    end
  end
  assign drain_timeout = drain_timeout_q;
`else
  assign drain_timeout = 1'b0;
`endif

  assign pr_freeze = pr_freeze_q;
  assign softreset = softreset_q;
  assign pr_ready  = pr_ready_q;
  assign state_o   = state_q;

  // Ordering invariants the freeze bridges and AFU rely on.
  a_ready_implies_isolated: assert property (@(posedge clk) disable iff (reset)
    pr_ready_q |-> (pr_freeze_q && softreset_q));
  a_no_reset_release_frozen: assert property (@(posedge clk) disable iff (reset)
    $fell(softreset_q) |-> !$past(pr_freeze_q));
  a_no_freeze_in_swrst: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_SWRST) |-> !$rose(pr_freeze_q));

endmodule

// File: doc/pr_slot_freeze_ctrl.md
Name: pr_slot_freeze_ctrl

Overview:
- Sequences PR-slot isolation: generates `pr_freeze` and `softreset` for the PR slot freeze bridges (PCIe A/B, EMIF, HSSI) and the AFU.
- On a host PR request, it freezes the slot, waits for the slot interfaces to go quiet, then asserts AFU reset and signals PR-ready.
- After PR completes, it releases freeze before reset, so the downstream synchronizers in the EMIF/HSSI domains see an ordered sequence.
- Sits in the port gasket on the `clk` domain, beside the PR slot.

Parameters:
- NUM_BUSY, 4, number of activity inputs (PCIe A tx, PCIe B tx, EMIF outstanding, HSSI tx).
- QUIET_CYCLES, 16, consecutive all-idle cycles required before the slot counts as drained (>=1).
- RST_HOLD_CYCLES, 32, minimum cycles `softreset` stays high after PR done (>=1).
- SYNC_CYCLES, 8, cycles between freeze deassert and reset release (covers 2-flop resyncs plus the `clk` freeze pipeline).
- TIMEOUT_CYCLES, 4096, drain timeout; used only with the optional feature.
- CNT_W, 13, counter width; must hold max(QUIET_CYCLES, RST_HOLD_CYCLES, SYNC_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  slot clock
- reset  in  1  synchronous, active-high reset
- pr_req  in  1  level; high = host requests PR; drop = PR done
- sw_reset_req  in  1  pulse; AFU soft reset without PR
- busy  in  NUM_BUSY  per-interface activity (valid or outstanding), `clk` domain
- pr_freeze  out  1  to freeze bridges
- softreset  out  1  active-high AFU reset
- pr_ready  out  1  slot frozen and in reset; safe to reconfigure
- state_o  out  3  current state encoding, for CSR readback
- drain_timeout  out  1  sticky flag: drain timed out

Behaviour:
- All outputs are registered. On reset: state=INIT, pr_freeze=0, softreset=1, pr_ready=0, drain_timeout=0, counter=0.
- Encodings: INIT=0, RUN=1, DRAIN=2, FROZEN=3, HOLD=4, UNFREEZE=5, SWRST=6.
- INIT: softreset=1. Counts RST_HOLD_CYCLES, then goes to RUN.
- RUN: freeze=0, softreset=0.
  - pr_req=1 -> DRAIN.
  - Else sw_reset_req=1 -> SWRST.
  - If both are high in the same cycle, pr_req wins and sw_reset_req is dropped.
- DRAIN: pr_freeze=1 from the first cycle in this state.
  - Counter counts consecutive cycles with busy==0; any busy bit set clears it to 0.
  - Counter reaches QUIET_CYCLES-1 with busy==0 -> FROZEN.
  - pr_req dropping during DRAIN aborts to UNFREEZE; softreset is never asserted on this path.
- FROZEN: pr_freeze=1, softreset=1, pr_ready=1.
  - Stays here while pr_req=1.
  - pr_req=0 -> HOLD; pr_ready drops in the same cycle as the transition.
- HOLD: freeze=1, softreset=1. Counts RST_HOLD_CYCLES -> UNFREEZE.
- UNFREEZE: pr_freeze=0, softreset unchanged (1 if arriving from HOLD, 0 if aborted from DRAIN). Counts SYNC_CYCLES -> RUN, where softreset clears.
- SWRST: freeze=0, softreset=1. Counts RST_HOLD_CYCLES -> RUN. sw_reset_req pulses while here are ignored.
- pr_req re-asserted during HOLD or UNFREEZE: the sequence completes, and RUN re-enters DRAIN on the next cycle.
- Counter: zeroed on every state entry; saturates, never wraps.
- Invariants (asserted in simulation):
  - pr_ready implies pr_freeze && softreset.
  - softreset never falls while pr_freeze=1.
  - pr_freeze never rises while state=SWRST.
- Latency pr_req -> pr_freeze: 1 cycle. Minimum pr_req -> pr_ready: QUIET_CYCLES+1 cycles.
- reset asserted mid-sequence -> INIT immediately. pr_freeze drops the next cycle, and softreset is held for the INIT count.

Optional Feature:
- Macro: PR_SLOT_DRAIN_TIMEOUT_EN.
- Defined: DRAIN also runs a timeout counter. After TIMEOUT_CYCLES in DRAIN without quiescence, the block forces FROZEN and sets drain_timeout=1. drain_timeout clears only on reset.
- Undefined: DRAIN waits indefinitely; drain_timeout is tied to 0 and the timeout counter is not built.

Decomposition:
- Package pr_slot_ctrl_pkg holds:
  - the state enum t_frz_state (3-bit, values above);
  - default localparams for the cycle counts.
- One sub-module, pr_slot_quiet_detect: consecutive-idle counter over the busy vector with clear and done outputs. It is reusable for per-link drain monitoring.
- The top level holds the FSM and output registers.

Test Plan:
- Reset for 5 cycles, then release -> softreset=1 for 32 cycles, state_o=1; pr_freeze=0 throughout.
- pr_req=1 with busy=0 -> pr_freeze=1 at +1 cycle, pr_ready=1 at +17.
  - Drop pr_req -> softreset high 32 more cycles, pr_freeze falls, softreset falls 8 cycles later.
- pr_req=1 with busy[2] toggling every 10 cycles for 100 cycles, then 0 -> pr_ready only 16 cycles after the last busy. Check the quiet counter restarts on every toggle.
- pr_req pulse of 5 cycles with busy=4'hF -> state DRAIN -> UNFREEZE -> RUN; softreset never asserted.
- sw_reset_req and pr_req high in the same cycle -> DRAIN entered, no SWRST. Separately, a sw_reset_req pulse -> softreset 32 cycles with pr_freeze=0.
- PR_SLOT_DRAIN_TIMEOUT_EN defined, busy stuck at 1 -> FROZEN after 4096 cycles, drain_timeout=1 and sticky through a full PR cycle. Without the macro -> state stays DRAIN after 10000 cycles.
